// File: rtl/stride_walker.sv
// Strided address generator: accumulates per-loop-level strides from a small table onto a base address.
// Optional bound checking is built when STRIDE_WALKER_BOUND_CHECK_EN is defined.
module stride_walker #(
  parameter int ADDR_W   = 32,
  parameter int STRIDE_W = 16,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_wr_v,
  input  logic [STRIDE_W-1:0] cfg_wr_stride,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   addr_limit,
  input  logic                start,
  input  logic [IDX_W-1:0]    loop_index,
  input  logic                loop_index_valid,
  input  logic                loop_done,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_valid,
  output logic                walk_done,
  output logic                busy,
  output logic                cfg_err,
  output logic                oob_err
);

  // Handshake: every input strobe is sampled on a single rising edge with no
  // backpressure; addr_valid marks exactly one cycle per generated address.

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                drain_last, drain_last_nxt;
  logic [STRIDE_W-1:0] stride_tbl [DEPTH];
  logic [IDX_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic [STRIDE_W-1:0] rd_stride;
  logic                rd_v;
  logic                tbl_we;

  assign tbl_we    = cfg_wr_v && (state == IDLE);
  assign busy      = (state != IDLE);
  assign next_addr = cur_addr + ADDR_W'($signed(rd_stride));

  always_comb begin
    state_nxt      = state;
    drain_last_nxt = drain_last;
    walk_done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (loop_done) begin
          state_nxt      = DRAIN;
          drain_last_nxt = 1'b0;
        end
      end
      DRAIN: begin
        // Two drain cycles give the last accepted index time to reach addr_out.
        if (drain_last) begin
          state_nxt = IDLE;
          walk_done = 1'b1;
        end else begin
          drain_last_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      drain_last <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_last <= drain_last_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (walk_done) begin
      wr_ptr <= '0;
    end else if (tbl_we) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Table storage and read register are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (tbl_we) stride_tbl[wr_ptr] <= cfg_wr_stride;
    rd_stride <= stride_tbl[loop_index];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v       <= 1'b0;
      cur_addr   <= '0;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      rd_v       <= (state == RUN) && loop_index_valid;
      addr_valid <= 1'b0;
      if ((state == IDLE) && start) begin
        cur_addr   <= base_addr;
        addr_out   <= base_addr;
        addr_valid <= 1'b1;
      end else if (rd_v) begin
        cur_addr   <= next_addr;
        addr_out   <= next_addr;
        addr_valid <= 1'b1;
      end
      if (cfg_wr_v && (state != IDLE)) cfg_err <= 1'b1;
    end
  end

`ifdef STRIDE_WALKER_BOUND_CHECK_EN
  logic oob_hit;
  logic oob_q;

  // Flag the offending address in the same cycle it is emitted, then hold.
  assign oob_hit = addr_valid && (addr_out >= addr_limit);
  assign oob_err = oob_q | oob_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) oob_q <= 1'b0;
    else if (oob_hit) oob_q <= 1'b1;
  end
`else
  logic unused_addr_limit;
  assign unused_addr_limit = ^addr_limit;
  assign oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_stride_walker.sv
// Directed bench for stride_walker: table-driven walk plus hand sequences for
// burst, wrap, config error, mid-walk reset, pointer wrap and bound check.
module tb_stride_walker;

`ifdef STRIDE_WALKER_BOUND_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cfg_wr_v;
  logic [15:0] cfg_wr_stride;
  logic [31:0] base_addr;
  logic [31:0] addr_limit;
  logic        start;
  logic [3:0]  loop_index;
  logic        loop_index_valid;
  logic        loop_done;
  logic [31:0] addr_out;
  logic        addr_valid;
  logic        walk_done;
  logic        busy;
  logic        cfg_err;
  logic        oob_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  stride_walker #(.ADDR_W(32), .STRIDE_W(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .cfg_wr_v(cfg_wr_v), .cfg_wr_stride(cfg_wr_stride),
    .base_addr(base_addr), .addr_limit(addr_limit), .start(start),
    .loop_index(loop_index), .loop_index_valid(loop_index_valid), .loop_done(loop_done),
    .addr_out(addr_out), .addr_valid(addr_valid), .walk_done(walk_done),
    .busy(busy), .cfg_err(cfg_err), .oob_err(oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] stride;
    logic        st;
    logic [31:0] base;
    logic        iv;
    logic [3:0]  idx;
    logic        ld;
    logic        e_av;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_wd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; outputs are checked just after.
  task automatic cyc(input logic wr, input logic [15:0] stride, input logic st,
                     input logic [31:0] base, input logic iv, input logic [3:0] idx,
                     input logic ld);
    @(negedge clk);
    cfg_wr_v         = wr;
    cfg_wr_stride    = stride;
    start            = st;
    base_addr        = base;
    loop_index_valid = iv;
    loop_index       = idx;
    loop_done        = ld;
    #1;
  endtask

  task automatic expect_addr(input string name, input logic [31:0] a);
    check({name, "_valid"}, {31'd0, addr_valid}, 32'd1);
    if (addr_valid) check({name, "_addr"}, addr_out, a);
  endtask

  initial begin
    reset = 1'b1;
    addr_limit = 32'hFFFF_FFFF;
    cfg_wr_v = 0; cfg_wr_stride = 0; start = 0; base_addr = 0;
    loop_index_valid = 0; loop_index = 0; loop_done = 0;

    //        wr  stride     st  base          iv idx ld  av addr          busy wd
    vecs[0]  = '{1'b1, 16'd4,    1'b0, 32'h0,    1'b1, 4'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'd64,   1'b0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'hFFC4, 1'b0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    vecs[3]  = '{1'b0, 16'd0,    1'b1, 32'h1000, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b1, 4'd0, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b1, 4'd0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b1, 4'd1, 1'b0, 1'b1, 32'h1004, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 16'd0,    1'b1, 32'h5000, 1'b0, 4'd0, 1'b0, 1'b1, 32'h1008, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b0, 4'd0, 1'b1, 1'b1, 32'h1048, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1};
    vecs[11] = '{1'b0, 16'd0,    1'b0, 32'h0,    1'b0, 4'd0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
    check("rst_addr_out", addr_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_walk_done", {31'd0, walk_done}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_oob_err", {31'd0, oob_err}, 32'd0);
    reset = 1'b0;

    // Basic walk with strides {4,64,-60}
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].wr, vecs[i].stride, vecs[i].st, vecs[i].base,
          vecs[i].iv, vecs[i].idx, vecs[i].ld);
      check($sformatf("vec%0d_valid", i), {31'd0, addr_valid}, {31'd0, vecs[i].e_av});
      if (vecs[i].e_av) check($sformatf("vec%0d_addr", i), addr_out, vecs[i].e_addr);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("vec%0d_walk_done", i), {31'd0, walk_done}, {31'd0, vecs[i].e_wd});
    end

    // Back-to-back index 0 with stride 1, loop_done together with the last index
    cyc(1, 16'd1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h1000, 0, 0, 0);
    for (int k = 1; k <= 8; k++) exp_q.push_back(32'h1000 + k);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 0, 0, 0, j < 8, 4'd0, j == 7);
      if (j == 0) expect_addr("burst_base", 32'h1000);
      else if (j == 1) check("burst_gap0", {31'd0, addr_valid}, 32'd0);
      else begin
        check($sformatf("burst%0d_valid", j), {31'd0, addr_valid}, 32'd1);
        if (addr_valid && exp_q.size() > 0)
          check($sformatf("burst%0d_addr", j), addr_out, exp_q.pop_front());
      end
      check($sformatf("burst%0d_walk_done", j), {31'd0, walk_done}, {31'd0, j == 9});
    end
    check("burst_queue_empty", exp_q.size(), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("burst_idle_busy", {31'd0, busy}, 32'd0);
    check("burst_idle_valid", {31'd0, addr_valid}, 32'd0);

    // Negative stride wraps below zero; write during RUN flags cfg_err only
    cyc(0, 0, 1, 32'h10, 0, 0, 0);
    cyc(1, 16'h7777, 0, 0, 1, 4'd2, 0);
    expect_addr("wrap_base", 32'h10);
    cyc(0, 0, 0, 0, 1, 4'd1, 0);
    check("cfg_err_set", {31'd0, cfg_err}, 32'd1);
    cyc(0, 0, 0, 0, 1, 4'd0, 0);
    expect_addr("wrap_down", 32'hFFFF_FFD4);
    cyc(0, 0, 0, 0, 0, 0, 1);
    expect_addr("wrap_up", 32'h14);
    cyc(0, 0, 0, 0, 0, 0, 0);
    expect_addr("tbl_unchanged", 32'h15);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("wrap_walk_done", {31'd0, walk_done}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("cfg_err_sticky", {31'd0, cfg_err}, 32'd1);

    // Reset one cycle after an accepted index drops the in-flight address
    cyc(0, 0, 1, 32'h2000, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 0);
    expect_addr("pre_reset", 32'h2000);
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, addr_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      check($sformatf("post_rst%0d_valid", j), {31'd0, addr_valid}, 32'd0);
      check($sformatf("post_rst%0d_busy", j), {31'd0, busy}, 32'd0);
    end

    // 17 writes wrap the pointer onto entry 0; the 18th lands in entry 1
    for (int i = 0; i < 17; i++) cyc(1, 16'(100 + i), 0, 0, 0, 0, 0);
    cyc(1, 16'd200, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 0);
    expect_addr("ptr_base", 32'd0);
    cyc(0, 0, 0, 0, 1, 4'd1, 0);
    cyc(0, 0, 0, 0, 1, 4'd2, 1);
    expect_addr("ptr_entry0", 32'd116);
    cyc(0, 0, 0, 0, 0, 0, 0);
    expect_addr("ptr_entry1", 32'd316);
    cyc(0, 0, 0, 0, 0, 0, 0);
    expect_addr("ptr_entry2", 32'd418);
    check("ptr_walk_done", {31'd0, walk_done}, 32'd1);

    // Bound check at limit 0x1008 with stride 4 from 0x1000
    cyc(1, 16'd4, 0, 0, 0, 0, 0);
    addr_limit = 32'h1008;
    cyc(0, 0, 1, 32'h1000, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4'd0, 0);
    expect_addr("oob_a0", 32'h1000);
    check("oob_a0_err", {31'd0, oob_err}, 32'd0);
    cyc(0, 0, 0, 0, 1, 4'd0, 0);
    check("oob_gap_err", {31'd0, oob_err}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    expect_addr("oob_a1", 32'h1004);
    check("oob_a1_err", {31'd0, oob_err}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    expect_addr("oob_a2", 32'h1008);
    check("oob_a2_err", {31'd0, oob_err}, {31'd0, BC});
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("oob_sticky", {31'd0, oob_err}, {31'd0, BC});
    check("oob_walk_done", {31'd0, walk_done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
